alu_seq_muldiv: RTL and testbench

//  Parametrised, registered-output successor of the combinational datapath ALU.

---
 rtl/alu_seq_muldiv_if.sv | 27 ++
 rtl/alu_seq_muldiv.sv | 214 +++++++++++++++++++++
 tb/tb_alu_seq_muldiv.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_muldiv_if.sv
// Handshake and operand/result bundle between the ID/EX latches, the ALU and the EX/MEM register.
interface alu_seq_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             iValid;
  logic             oReady;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic [5:0]       iALUFun;
  logic             iSign;
  logic             oValid;
  logic             iReady;
  logic [WIDTH-1:0] oS;
  logic             oZ;
  logic             oV;
  logic             oN;

  modport master (
    output iValid, iA, iB, iALUFun, iSign, iReady,
    input  oReady, oValid, oS, oZ, oV, oN
  );

  modport slave (
    input  iValid, iA, iB, iALUFun, iSign, iReady,
    output oReady, oValid, oS, oZ, oV, oN
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Registered-output ALU with the 6-bit ALUFun op set and a valid/ready handshake.
// Define ALU_MULDIV_EN to add iterative MUL/DIV; otherwise those codes decode as undefined.
module alu_seq_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input logic             iClk,
  input logic             iRst_n,
  alu_seq_muldiv_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for an op, oReady high
  // BUSY  | MUL/DIV iterating, one bit per cycle
  // DONE  | result held on oS/flags until iReady
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int MSB = WIDTH - 1;
  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001,
                         OP_AND = 6'b011000, OP_OR  = 6'b011110, OP_XOR = 6'b010110,
                         OP_NOR = 6'b010001, OP_A   = 6'b011010, OP_LUI = 6'b011011,
                         OP_SLL = 6'b100000, OP_SRL = 6'b100001, OP_SRA = 6'b100011,
                         OP_EQ  = 6'b110011, OP_NEQ = 6'b110001, OP_LT  = 6'b110101,
                         OP_LEZ = 6'b111101, OP_GEZ = 6'b111001, OP_GTZ = 6'b111111;

  state_t           state, nextState;
  logic [WIDTH-1:0] a, b, res, sReg, mdS;
  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   shamt;
  logic             resV, resN, arithOp, goBusy, lastIter, accept;
  logic             zReg, vReg, nReg, mdV, mdN;

  assign a      = bus.iA;
  assign b      = bus.iB;
  assign accept = bus.iValid & (state == IDLE);

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    shamt   = a[SHW-1:0];
    res     = '0;
    resV    = 1'b0;
    resN    = 1'b0;
    arithOp = 1'b0;
    case (bus.iALUFun)
      OP_ADD: begin
        arithOp = 1'b1;
        res     = sum[MSB:0];
        if (bus.iSign) begin
          resV = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
          resN = res[MSB] ^ resV;
        end else begin
          resV = sum[WIDTH];
        end
      end
      OP_SUB: begin
        arithOp = 1'b1;
        res     = diff[MSB:0];
        if (bus.iSign) begin
          resV = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
          resN = res[MSB] ^ resV;
        end else begin
          resV = diff[WIDTH];
          resN = diff[WIDTH];
        end
      end
`ifdef ALU_MULDIV_EN
      6'b000011: begin
        // only reaches the result register when dividing by zero
        arithOp = 1'b1;
        res     = '1;
        resV    = 1'b1;
      end
`endif
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOR: res = ~(a | b);
      OP_A:   res = a;
      OP_LUI: res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLL: res = b << shamt;
      OP_SRL: res = b >> shamt;
      OP_SRA: res = $signed(b) >>> shamt;
      OP_EQ:  res = {{MSB{1'b0}}, a == b};
      OP_NEQ: res = {{MSB{1'b0}}, a != b};
      OP_LT:  res = {{MSB{1'b0}}, bus.iSign ? ($signed(a) < $signed(b)) : (a < b)};
      OP_LEZ: res = {{MSB{1'b0}}, $signed(a) <= 0};
      OP_GEZ: res = {{MSB{1'b0}}, $signed(a) >= 0};
      OP_GTZ: res = {{MSB{1'b0}}, $signed(a) > 0};
      default: res = '0;
    endcase
    if (!arithOp) resN = bus.iSign & res[MSB];
  end

`ifdef ALU_MULDIV_EN
  localparam logic [5:0] OP_MUL = 6'b000010, OP_DIV = 6'b000011;

  logic [2*WIDTH-1:0] acc, accNext, mcand, prod;
  logic [WIDTH-1:0]   qReg, qNext, magA, magB, quo;
  logic [WIDTH:0]     trial;
  logic [SHW-1:0]     cnt;
  logic               isDiv, negRes, sgn, minOvf;

  assign goBusy   = (bus.iALUFun == OP_MUL) || ((bus.iALUFun == OP_DIV) && (b != '0));
  assign lastIter = (cnt == '0);
  assign magA     = (bus.iSign & a[MSB]) ? -a : a;
  assign magB     = (bus.iSign & b[MSB]) ? -b : b;

  // MUL: acc += mcand when the multiplier LSB is set. DIV: restoring step on the remainder in acc.
  always_comb begin
    accNext = acc;
    qNext   = qReg;
    trial   = {acc[MSB:0], qReg[MSB]} - {1'b0, mcand[MSB:0]};
    if (isDiv) begin
      accNext = trial[WIDTH] ? {{WIDTH{1'b0}}, acc[MSB-1:0], qReg[MSB]}
                             : {{WIDTH{1'b0}}, trial[MSB:0]};
      qNext   = {qReg[MSB-1:0], ~trial[WIDTH]};
    end else begin
      if (qReg[0]) accNext = acc + mcand;
      qNext = qReg >> 1;
    end
    prod = negRes ? -accNext : accNext;
    quo  = negRes ? -qNext : qNext;
    if (isDiv) begin
      mdS = quo;
      mdV = minOvf;
      mdN = sgn & quo[MSB];
    end else begin
      mdS = prod[MSB:0];
      mdV = sgn ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[MSB]}}) : (prod[2*WIDTH-1:WIDTH] != '0);
      mdN = sgn & prod[MSB];
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      acc    <= '0;
      mcand  <= '0;
      qReg   <= '0;
      cnt    <= '0;
      isDiv  <= 1'b0;
      negRes <= 1'b0;
      sgn    <= 1'b0;
      minOvf <= 1'b0;
    end else if (accept && goBusy) begin
      isDiv  <= (bus.iALUFun == OP_DIV);
      sgn    <= bus.iSign;
      negRes <= bus.iSign & (a[MSB] ^ b[MSB]);
      minOvf <= bus.iSign & (a == {1'b1, {MSB{1'b0}}}) & (b == '1);
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, (bus.iALUFun == OP_DIV) ? magB : magA};
      qReg   <= (bus.iALUFun == OP_DIV) ? magA : magB;
      cnt    <= SHW'(WIDTH - 1);
    end else if (state == BUSY) begin
      acc  <= accNext;
      qReg <= qNext;
      cnt  <= cnt - SHW'(1);
      if (!isDiv) mcand <= mcand << 1;
    end
  end
`else
  assign goBusy   = 1'b0;
  assign lastIter = 1'b0;
  assign mdS      = '0;
  assign mdV      = 1'b0;
  assign mdN      = 1'b0;
`endif

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState  = state;
    bus.oReady = 1'b0;
    bus.oValid = 1'b0;
    case (state)
      IDLE: begin
        bus.oReady = 1'b1;
        if (bus.iValid) nextState = goBusy ? BUSY : DONE;
      end
      BUSY: if (lastIter) nextState = DONE;
      DONE: begin
        bus.oValid = 1'b1;
        if (bus.iReady) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sReg <= '0;
      zReg <= 1'b0;
      vReg <= 1'b0;
      nReg <= 1'b0;
    end else if (accept && !goBusy) begin
      sReg <= res;
      zReg <= (res == '0);
      vReg <= resV;
      nReg <= resN;
    end else if ((state == BUSY) && lastIter) begin
      sReg <= mdS;
      zReg <= (mdS == '0);
      vReg <= mdV;
      nReg <= mdN;
    end
  end

  assign bus.oS = sReg;
  assign bus.oZ = zReg;
  assign bus.oV = vReg;
  assign bus.oN = nReg;
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed plus randomized bench for alu_seq_muldiv against an arithmetic reference model.
module tb_alu_seq_muldiv;
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_seq_muldiv_if #(.WIDTH(32)) bus ();

  alu_seq_muldiv #(.WIDTH(32), .SHW(5)) dut (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .bus   (bus)
  );

  always #5 iClk = ~iClk;

  logic [5:0] opList [20] = '{6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b011000,
                              6'b011110, 6'b010110, 6'b010001, 6'b011010, 6'b011011,
                              6'b100000, 6'b100001, 6'b100011, 6'b110011, 6'b110001,
                              6'b110101, 6'b111101, 6'b111001, 6'b111111, 6'b111110};
  logic [31:0] edgeVals [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected result from plain integer arithmetic on the operand values.
  function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic sg, output logic [31:0] s, output logic z,
                                output logic v, output logic n, output bit multi);
    longint sa, sb, r, sa32;
    logic   logicN;
    sa   = sg ? longint'($signed(a)) : longint'(a);
    sb   = sg ? longint'($signed(b)) : longint'(b);
    if (sg) begin sa = longint'($signed(a)); sb = longint'($signed(b)); end
    else begin sa = longint'(a); sb = longint'(b); end
    sa32 = longint'($signed(a));
    r = 0; s = '0; v = 1'b0; n = 1'b0; multi = 1'b0; logicN = 1'b1;
    case (op)
      6'b000000, 6'b000001: begin
        logicN = 1'b0;
        r = (op == 6'b000000) ? sa + sb : sa - sb;
        s = r[31:0];
        if (sg) begin
          v = (r > SMAX) || (r < SMIN);
          n = (r < 0);
        end else if (op == 6'b000000) begin
          v = (r > longint'(32'hFFFFFFFF));
        end else begin
          v = (r < 0);
          n = (r < 0);
        end
      end
`ifdef ALU_MULDIV_EN
      6'b000010: begin
        logicN = 1'b0;
        multi  = 1'b1;
        r = sa * sb;
        s = r[31:0];
        v = sg ? ((r > SMAX) || (r < SMIN)) : (r[63:32] != 32'h0);
        n = sg & s[31];
      end
      6'b000011: begin
        logicN = 1'b0;
        if (b == 32'h0) begin
          s = 32'hFFFFFFFF; v = 1'b1;
        end else begin
          multi = 1'b1;
          if (sg && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            s = 32'h80000000; v = 1'b1; n = 1'b1;
          end else begin
            r = sa / sb;
            s = r[31:0];
            n = sg & s[31];
          end
        end
      end
`endif
      6'b011000: s = a & b;
      6'b011110: s = a | b;
      6'b010110: s = a ^ b;
      6'b010001: s = ~(a | b);
      6'b011010: s = a;
      6'b011011: s = {b[15:0], 16'h0};
      6'b100000: begin r = longint'(b) << a[4:0]; s = r[31:0]; end
      6'b100001: begin r = longint'(b) >> a[4:0]; s = r[31:0]; end
      6'b100011: begin r = longint'($signed(b)) >>> a[4:0]; s = r[31:0]; end
      6'b110011: s = {31'h0, a == b};
      6'b110001: s = {31'h0, a != b};
      6'b110101: s = {31'h0, sa < sb};
      6'b111101: s = {31'h0, sa32 <= 0};
      6'b111001: s = {31'h0, sa32 >= 0};
      6'b111111: s = {31'h0, sa32 > 0};
      default:   s = '0;
    endcase
    if (logicN) n = sg & s[31];
    z = (s == 32'h0);
  endfunction

  // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
  task automatic runOp(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic sg, input int hold, input string tag);
    logic [31:0] es;
    logic        ez, ev, en, sawReady;
    bit          multi;
    int          k;
    model(op, a, b, sg, es, ez, ev, en, multi);
    check({tag, ":rdy"}, 64'(bus.oReady), 64'd1);
    bus.iValid = 1'b1; bus.iA = a; bus.iB = b; bus.iALUFun = op; bus.iSign = sg; bus.iReady = 1'b0;
    @(posedge iClk); #1;
    bus.iValid = 1'b0; bus.iA = $urandom; bus.iB = $urandom;
    bus.iALUFun = 6'($urandom); bus.iSign = 1'($urandom);
    @(negedge iClk);
    k = 0; sawReady = 1'b0;
    while (bus.oValid !== 1'b1 && k < 100) begin
      sawReady |= (bus.oReady !== 1'b0);
      @(negedge iClk);
      k++;
    end
    check({tag, ":lat"}, 64'(k), multi ? 64'd32 : 64'd0);
    check({tag, ":busyrdy"}, 64'({sawReady, bus.oReady}), 64'd0);
    check({tag, ":res"}, 64'({bus.oS, bus.oZ, bus.oV, bus.oN}), 64'({es, ez, ev, en}));
    for (int i = 0; i < hold; i++) begin
      bus.iA = $urandom; bus.iB = $urandom;
      @(negedge iClk);
      check({tag, ":hold"}, 64'({bus.oValid, bus.oReady, bus.oS, bus.oZ, bus.oV, bus.oN}),
            64'({1'b1, 1'b0, es, ez, ev, en}));
    end
    bus.iReady = 1'b1;
    @(negedge iClk);
    bus.iReady = 1'b0;
    check({tag, ":ret"}, 64'({bus.oValid, bus.oReady}), 64'b01);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bus.iValid = 1'b0; bus.iA = '0; bus.iB = '0; bus.iALUFun = '0; bus.iSign = 1'b0; bus.iReady = 1'b0;
    repeat (2) @(negedge iClk);
    check("reset", 64'({bus.oValid, bus.oS, bus.oZ, bus.oV, bus.oN}), 64'd0);
    iRst_n = 1'b1;
    @(negedge iClk);
    check("reset:rdy", 64'({bus.oReady, bus.oValid}), 64'b10);

    runOp(6'b000000, 32'h7FFFFFFF, 32'h1, 1'b1, 0, "add_ovf");
    runOp(6'b000001, 32'h3, 32'h5, 1'b0, 0, "sub_u");
    runOp(6'b000001, 32'h3, 32'h5, 1'b1, 0, "sub_s");
    runOp(6'b000000, 32'hFFFFFFFF, 32'h1, 1'b0, 0, "add_carry");
    runOp(6'b000010, 32'hFFFFFFFD, 32'h7, 1'b1, 0, "mul_neg");
    runOp(6'b000010, 32'h10000, 32'h10000, 1'b0, 1, "mul_ovf");
    runOp(6'b000011, 32'hFFFFFFF9, 32'h2, 1'b1, 0, "div_neg");
    runOp(6'b000011, 32'h1234, 32'h0, 1'b0, 0, "div_zero");
    runOp(6'b000011, 32'h80000000, 32'hFFFFFFFF, 1'b1, 0, "div_min");
    runOp(6'b100011, 32'h4, 32'h80000000, 1'b0, 5, "sra_hold");
    runOp(6'b011011, 32'h0, 32'hABCD1234, 1'b1, 0, "lui");
    runOp(6'b110101, 32'hFFFFFFFF, 32'h1, 1'b1, 0, "lt_s");
    runOp(6'b110101, 32'hFFFFFFFF, 32'h1, 1'b0, 0, "lt_u");
    runOp(6'b111101, 32'h0, 32'h0, 1'b0, 0, "lez_zero");
    runOp(6'b111110, 32'h5, 32'h6, 1'b1, 0, "undef");

    for (int t = 0; t < 40; t++) begin
      ra = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 4)] : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 4)] : 32'($urandom);
      runOp(opList[$urandom_range(0, 19)], ra, rb, 1'($urandom), $urandom_range(0, 2),
            $sformatf("rand%0d", t));
    end

    runOp(6'b010110, 32'hF0F0F0F0, 32'h0F0F0F00, 1'b0, 0, "xor_pre");
    bus.iValid = 1'b1; bus.iA = 32'hFFFFFFFD; bus.iB = 32'h7; bus.iALUFun = 6'b000010; bus.iSign = 1'b1;
    @(posedge iClk); #1;
    bus.iValid = 1'b0;
    repeat (10) @(negedge iClk);
    iRst_n = 1'b0;
    #1;
    check("midrst", 64'({bus.oValid, bus.oS, bus.oZ, bus.oV, bus.oN}), 64'd0);
    @(negedge iClk);
    iRst_n = 1'b1;
    @(negedge iClk);
    check("midrst:rdy", 64'({bus.oReady, bus.oValid}), 64'b10);
    runOp(6'b000010, 32'hFFFFFFFD, 32'h7, 1'b1, 0, "mul_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
